ptmch_evtlog: RTL

Trigger event logger placed directly downstream of the SPI instruction-match trigger generator; consumes its 5-bit `TRG_PLS` bus on `CLK160M`. Detects the rising edge of each trigger channel, counts events per channel, and queues `{channel, timestamp}` records in a first-word-fall-through FIFO. The FIFO is drained by the host-side register/readout logic over a valid/ready handshake.

---
 rtl/ptmch_evtlog.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ptmch_evtlog.sv
// Trigger event logger: rising-edge detect on TRG_PLS, saturating per-channel
// counters, one-deep pending stage per channel and a FWFT {ch, ts} event FIFO.
module ptmch_evtlog #(
  parameter int P_TS_W  = 24,
  parameter int P_DEPTH = 16,
  parameter int P_CNT_W = 16
) (
  input  logic                       CLK160M,
  input  logic                       RESET,
  input  logic [4:0]                 TRG_PLS,
  input  logic                       EN,
  input  logic                       CLR,
  input  logic                       EVT_READY,
  output logic                       EVT_VALID,
  output logic [P_TS_W+2:0]          EVT_DATA,
  output logic [$clog2(P_DEPTH):0]   EVT_LEVEL,
  output logic                       EVT_OVF,
  input  logic [2:0]                 CNT_SEL,
  output logic [P_CNT_W-1:0]         CNT_VAL
);

  localparam int AW  = $clog2(P_DEPTH);
  localparam int DW  = P_TS_W + 3;
  localparam int NCH = 5;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(P_DEPTH);

  logic               srst;
  logic [P_TS_W-1:0]  ts_reg;
  logic [NCH-1:0]     trg_1d_reg;
  logic [NCH-1:0]     cap;
  logic [NCH-1:0]     drop;
  logic [NCH-1:0]     grant;
  logic [NCH-1:0]     pend_reg;
  logic [P_TS_W-1:0]  pts_reg [NCH];
  logic [P_CNT_W-1:0] cnt_reg [NCH];
  logic [P_CNT_W-1:0] cnt_sel_val;
  logic [P_CNT_W-1:0] cnt_val_reg;
  logic               ovf_reg;

  logic [DW-1:0]      mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        level_reg;
  logic               full;
  logic               push;
  logic               pop;
  logic [DW-1:0]      push_data;

  assign srst = RESET | CLR;
  assign cap  = TRG_PLS & ~trg_1d_reg & {NCH{EN}};
  assign full = (level_reg == FULL_LVL);
  assign pop  = (level_reg != '0) & EVT_READY;
  assign push = (|pend_reg) & (~full | pop);

  // Lowest pending channel wins; isolate its bit as the one-hot grant.
  assign grant = push ? (pend_reg & (~pend_reg + 5'd1)) : '0;

  always_comb begin
    push_data = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_reg[i]) push_data = {3'(i), pts_reg[i]};
    end
  end

  // A rise on a channel whose entry leaves this cycle re-arms it instead of dropping.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_drop
      assign drop[gi] = cap[gi] & pend_reg[gi] & ~grant[gi];
    end
  endgenerate

  always_comb begin
    case (CNT_SEL)
      3'd0:    cnt_sel_val = cnt_reg[0];
      3'd1:    cnt_sel_val = cnt_reg[1];
      3'd2:    cnt_sel_val = cnt_reg[2];
      3'd3:    cnt_sel_val = cnt_reg[3];
      3'd4:    cnt_sel_val = cnt_reg[4];
      default: cnt_sel_val = '0;
    endcase
  end

  always_ff @(posedge CLK160M) begin
    // Tracks the input even in reset so a level held across reset is not a new event.
    trg_1d_reg <= TRG_PLS;
    if (srst) begin
      ts_reg      <= '0;
      ovf_reg     <= 1'b0;
      pend_reg    <= '0;
      cnt_val_reg <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_reg[i] <= '0;
        pts_reg[i] <= '0;
      end
    end else begin
      ts_reg      <= ts_reg + P_TS_W'(1);
      cnt_val_reg <= cnt_sel_val;
      if (|drop) ovf_reg <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (cap[i] && (cnt_reg[i] != '1)) cnt_reg[i] <= cnt_reg[i] + P_CNT_W'(1);
        if (cap[i] && !drop[i]) begin
          pend_reg[i] <= 1'b1;
          pts_reg[i]  <= ts_reg;
        end else if (grant[i]) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK160M) begin
    if (push && !srst) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK160M) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      level_reg <= level_reg + (AW+1)'(1);
      else if (pop && !push) level_reg <= level_reg - (AW+1)'(1);
    end
  end

  assign EVT_VALID = (level_reg != '0);
  assign EVT_DATA  = EVT_VALID ? mem[rd_ptr_reg] : '0;
  assign EVT_LEVEL = level_reg;
  assign EVT_OVF   = ovf_reg;
  assign CNT_VAL   = cnt_val_reg;

endmodule
